// File: rtl/univ_shift_register.sv
// Universal shift register: hold/shift/rotate/asr/load/clear per cycle, plus a
// counted burst engine that runs N shifts from one start request with a
// busy/done handshake.
// Optional parity outputs and a sticky load-parity error flag are compiled in
// when SHREG_PARITY_EN is defined.
module univ_shift_register #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic             shift_in,
   input  logic [WIDTH-1:0] par_in,
   input  logic             start,
   input  logic [CNT_W-1:0] burst_len,
   output logic [WIDTH-1:0] q,
   output logic             ser_out_l,
   output logic             ser_out_r,
   output logic             busy,
   output logic             done
`ifdef SHREG_PARITY_EN
   ,
   input  logic             par_in_p,
   output logic             parity,
   output logic             par_err
`endif
);

   typedef enum logic [2:0] {
      OP_HOLD  = 3'b000,
      OP_SHL   = 3'b001,
      OP_SHR   = 3'b010,
      OP_ROTL  = 3'b011,
      OP_ROTR  = 3'b100,
      OP_LOAD  = 3'b101,
      OP_ASR   = 3'b110,
      OP_CLEAR = 3'b111
   } op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   logic [WIDTH-1:0] q_q, q_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   op_e              mode_q, mode_d;
   state_e           state_q, state_d;
   logic             done_q, done_d;
   op_e              op_live;
   logic             accept;

   // One register update for a given operation code.
   function automatic logic [WIDTH-1:0] apply_op(input op_e op,
                                                 input logic [WIDTH-1:0] v,
                                                 input logic si,
                                                 input logic [WIDTH-1:0] ld);
      logic [WIDTH-1:0] r;
      r = v;
      case (op)
         OP_SHL:   r = {v[WIDTH-2:0], si};
         OP_SHR:   r = {si, v[WIDTH-1:1]};
         OP_ROTL:  r = {v[WIDTH-2:0], v[WIDTH-1]};
         OP_ROTR:  r = {v[0], v[WIDTH-1:1]};
         OP_LOAD:  r = ld;
         OP_ASR:   r = {v[WIDTH-1], v[WIDTH-1:1]};
         OP_CLEAR: r = '0;
         default:  r = v;
      endcase
      return r;
   endfunction

   // Only shift/rotate codes may start a burst.
   function automatic logic is_shift(input op_e op);
      return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROTL) ||
             (op == OP_ROTR) || (op == OP_ASR);
   endfunction

   assign op_live = op_e'(mode);
   assign accept  = (state_q == ST_IDLE) && start && is_shift(op_live);

   // Next-state: burst accept beats the direct path; BUSY ignores all controls.
   always_comb begin
      q_d     = q_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               mode_d = op_live;
               cnt_d  = burst_len;
               if (burst_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = ST_BUSY;
               end
            end else if (en) begin
               q_d = apply_op(op_live, q_q, shift_in, par_in);
            end
         end
         ST_BUSY: begin
            q_d   = apply_op(mode_q, q_q, shift_in, par_in);
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_q     <= '0;
         cnt_q   <= '0;
         mode_q  <= OP_HOLD;
         state_q <= ST_IDLE;
         done_q  <= 1'b0;
      end else begin
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

   assign q         = q_q;
   assign ser_out_l = q_q[WIDTH-1];
   assign ser_out_r = q_q[0];
   assign busy      = (state_q == ST_BUSY);
   assign done      = done_q;

`ifdef SHREG_PARITY_EN
   logic par_err_q, par_err_d;
   logic direct_op;

   assign direct_op = (state_q == ST_IDLE) && !accept && en;

   // Sticky flag: set on a load with mismatching parity, cleared by clear op.
   always_comb begin
      par_err_d = par_err_q;
      if (direct_op && (op_live == OP_LOAD) && ((^par_in) != par_in_p)) begin
         par_err_d = 1'b1;
      end else if (direct_op && (op_live == OP_CLEAR)) begin
         par_err_d = 1'b0;
      end
   end

   // Parity error register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         par_err_q <= 1'b0;
      end else begin
         par_err_q <= par_err_d;
      end
   end

   assign parity  = ^q_q;
   assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_univ_shift_register.sv
// Self-checking bench for univ_shift_register: directed scenarios followed by
// randomized traffic, compared against a cycle-level reference model built on
// integer arithmetic and a remaining-shift count.
module tb_univ_shift_register;

   localparam int W  = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          en;
   logic [2:0]    mode;
   logic          shift_in;
   logic [W-1:0]  par_in;
   logic          start;
   logic [CW-1:0] burst_len;
   logic [W-1:0]  q;
   logic          ser_out_l;
   logic          ser_out_r;
   logic          busy;
   logic          done;
   logic          par_in_p;
`ifdef SHREG_PARITY_EN
   logic          parity;
   logic          par_err;
`endif

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Reference model state
   int unsigned q_m     = 0;
   int unsigned rem_m   = 0;
   int unsigned lmode_m = 0;
   int unsigned done_m  = 0;
   int unsigned perr_m  = 0;

   univ_shift_register #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .mode      (mode),
      .shift_in  (shift_in),
      .par_in    (par_in),
      .start     (start),
      .burst_len (burst_len),
      .q         (q),
      .ser_out_l (ser_out_l),
      .ser_out_r (ser_out_r),
      .busy      (busy),
      .done      (done)
`ifdef SHREG_PARITY_EN
      ,
      .par_in_p  (par_in_p),
      .parity    (parity),
      .par_err   (par_err)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: observed=0x%0h required=0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int unsigned ref_op(input int unsigned m, input int unsigned v,
                                          input int unsigned si, input int unsigned p);
      int unsigned msb  = 1 << (W - 1);
      int unsigned mask = (1 << W) - 1;
      case (m)
         1: return ((v << 1) | si) & mask;
         2: return (v >> 1) | (si * msb);
         3: return ((v << 1) & mask) | (v / msb);
         4: return (v >> 1) | ((v % 2) * msb);
         5: return p & mask;
         6: return (v >> 1) | (v & msb);
         7: return 0;
         default: return v;
      endcase
   endfunction

   function automatic int unsigned ones_parity(input int unsigned v);
      int unsigned c = 0;
      for (int i = 0; i < W; i++) c += (v >> i) & 1;
      return c % 2;
   endfunction

   // Advance the model by one rising edge using the inputs currently applied.
   task automatic model_edge();
      int unsigned nd = 0;
      int unsigned m  = int'(mode);
      if (rem_m != 0) begin
         q_m = ref_op(lmode_m, q_m, int'(shift_in), int'(par_in));
         rem_m--;
         if (rem_m == 0) nd = 1;
      end else if (start && (m == 1 || m == 2 || m == 3 || m == 4 || m == 6)) begin
         lmode_m = m;
         rem_m   = int'(burst_len);
         if (rem_m == 0) nd = 1;
      end else if (en) begin
         if (m == 5 && ones_parity(int'(par_in)) != int'(par_in_p)) perr_m = 1;
         if (m == 7) perr_m = 0;
         q_m = ref_op(m, q_m, int'(shift_in), int'(par_in));
      end
      done_m = nd;
   endtask

   task automatic model_reset();
      q_m = 0; rem_m = 0; lmode_m = 0; done_m = 0; perr_m = 0;
   endtask

   task automatic check_all();
      check_eq("q", int'(q), q_m);
      check_eq("busy", int'(busy), (rem_m != 0) ? 1 : 0);
      check_eq("done", int'(done), done_m);
      check_eq("ser_out_l", int'(ser_out_l), (q_m >> (W - 1)) & 1);
      check_eq("ser_out_r", int'(ser_out_r), q_m & 1);
`ifdef SHREG_PARITY_EN
      check_eq("parity", int'(parity), ones_parity(q_m));
      check_eq("par_err", int'(par_err), perr_m);
`endif
   endtask

   // Apply inputs, take one edge, update the model, and compare 1 time unit later.
   task automatic cycle(input logic e, input logic [2:0] m, input logic si,
                        input logic [W-1:0] p, input logic st, input logic [CW-1:0] bl);
      en = e; mode = m; shift_in = si; par_in = p; start = st; burst_len = bl;
      par_in_p = 1'($urandom_range(0, 1));
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic async_reset_pulse();
      reset = 1'b1;
      #1;
      model_reset();
      check_all();
      #1;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; mode = 3'b000; shift_in = 1'b0; par_in = '0;
      start = 1'b0; burst_len = '0; par_in_p = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      model_reset();
      check_all();
      reset = 1'b0;

      // Load and single-step operations
      cycle(1, 3'b101, 0, 8'hA5, 0, 0);
      check_eq("load_A5", int'(q), 32'hA5);
      check_eq("load_ser_l", int'(ser_out_l), 1);
      check_eq("load_ser_r", int'(ser_out_r), 1);
      cycle(1, 3'b001, 1, 8'h00, 0, 0);
      check_eq("shl", int'(q), 32'h4B);
      cycle(1, 3'b010, 0, 8'h00, 0, 0);
      check_eq("shr", int'(q), 32'h25);
      cycle(1, 3'b101, 0, 8'h80, 0, 0);
      cycle(1, 3'b110, 0, 8'h00, 0, 0);
      check_eq("asr", int'(q), 32'hC0);
      cycle(1, 3'b101, 0, 8'h81, 0, 0);
      cycle(1, 3'b011, 0, 8'h00, 0, 0);
      check_eq("rotl", int'(q), 32'h03);
      cycle(1, 3'b101, 0, 8'h81, 0, 0);
      cycle(1, 3'b100, 0, 8'h00, 0, 0);
      check_eq("rotr", int'(q), 32'hC0);
      cycle(0, 3'b111, 1, 8'h00, 0, 0);
      check_eq("en_low_hold", int'(q), 32'hC0);

      // Burst of 3 shl with noise on ignored inputs
      cycle(1, 3'b101, 0, 8'h01, 0, 0);
      cycle(1, 3'b001, 0, 8'hFF, 1, 3);
      check_eq("accept_q", int'(q), 32'h01);
      check_eq("accept_busy", int'(busy), 1);
      for (int i = 0; i < 3; i++)
         cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 0, 8'($urandom), 1'b0, 4'($urandom));
      check_eq("burst_q", int'(q), 32'h08);
      check_eq("burst_done", int'(done), 1);
      check_eq("burst_busy_end", int'(busy), 0);
      cycle(0, 3'b000, 0, 8'h00, 0, 0);
      check_eq("done_clears", int'(done), 0);

      // Zero-length burst and ignored start with load mode
      cycle(0, 3'b010, 1, 8'h00, 1, 0);
      check_eq("len0_done", int'(done), 1);
      check_eq("len0_busy", int'(busy), 0);
      check_eq("len0_q", int'(q), 32'h08);
      cycle(1, 3'b101, 0, 8'h3C, 1, 5);
      check_eq("start_load_en1", int'(q), 32'h3C);
      cycle(0, 3'b101, 0, 8'h77, 1, 5);
      check_eq("start_load_en0", int'(q), 32'h3C);

      // Back-to-back bursts with start held high
      cycle(0, 3'b011, 0, 8'h00, 1, 2);
      for (int i = 0; i < 6; i++) cycle(0, 3'b011, 0, 8'h00, 1, 2);
      cycle(0, 3'b000, 0, 8'h00, 0, 0);

      // Reset in the middle of a burst, then a clean burst
      cycle(1, 3'b101, 0, 8'h5A, 0, 0);
      cycle(0, 3'b001, 1, 8'h00, 1, 5);
      cycle(0, 3'b001, 1, 8'h00, 0, 0);
      cycle(0, 3'b001, 1, 8'h00, 0, 0);
      async_reset_pulse();
      check_eq("rst_q", int'(q), 0);
      check_eq("rst_busy", int'(busy), 0);
      cycle(0, 3'b001, 1, 8'h00, 1, 2);
      cycle(0, 3'b001, 1, 8'h00, 0, 0);
      cycle(0, 3'b001, 1, 8'h00, 0, 0);
      check_eq("post_rst_q", int'(q), 32'h03);
      check_eq("post_rst_done", int'(done), 1);

      // Randomized traffic including long bursts and occasional async resets
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 99) == 0) begin
            async_reset_pulse();
         end else begin
            cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 8'($urandom),
                  1'($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15)));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
